// File: rtl/mem_arbiter.sv
// Two-port arbiter for one single-port memory: port 0 (CPU) and port 1 (loader/DMA).
// Ties go to the port not served last; locked bursts are capped at MAXBEATS beats.
module mem_arbiter #(
    parameter int MAXBEATS = 8,
    parameter int WIDTH    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic             lock0,
    input  logic             lock1,
    input  logic [WIDTH-1:0] adr0,
    input  logic [WIDTH-1:0] adr1,
    input  logic [WIDTH-1:0] wd0,
    input  logic [WIDTH-1:0] wd1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wd,
    output logic             mem_we,
    input  logic [WIDTH-1:0] mem_rd
);
    localparam int BW = (MAXBEATS > 1) ? $clog2(MAXBEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAXBEATS - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state_reg, state_next;
    logic          prio_reg, prio_next;
    logic [BW-1:0] beat_reg, beat_next;

    logic [1:0] req_v, we_v, lock_v, gnt_v, ack_v, wr_v;
    logic       owner;
    logic       other;

    assign req_v  = {req1, req0};
    assign we_v   = {we1, we0};
    assign lock_v = {lock1, lock0};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign gnt_v[gi] = (state_reg == ((gi == 0) ? OWN0 : OWN1));
            assign ack_v[gi] = gnt_v[gi] & req_v[gi];
            assign wr_v[gi]  = ack_v[gi] & we_v[gi];
        end
    endgenerate

    assign gnt0    = gnt_v[0];
    assign gnt1    = gnt_v[1];
    assign ack0    = ack_v[0];
    assign ack1    = ack_v[1];
    assign mem_we  = |wr_v;
    assign mem_adr = gnt_v[0] ? adr0 : (gnt_v[1] ? adr1 : '0);
    assign mem_wd  = gnt_v[0] ? wd0  : (gnt_v[1] ? wd1  : '0);
    assign rdata   = mem_rd;

    assign owner = gnt_v[1];
    assign other = ~owner;

    always_comb begin
        state_next = state_reg;
        prio_next  = prio_reg;
        beat_next  = beat_reg;
        case (state_reg)
            IDLE: begin
                beat_next = '0;
                if (req0 && req1) begin
                    state_next = prio_reg ? OWN1 : OWN0;
                end else if (req0) begin
                    state_next = OWN0;
                end else if (req1) begin
                    state_next = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (ack_v[owner] && lock_v[owner] && (beat_reg < LAST_BEAT)) begin
                    beat_next = beat_reg + 1'b1;
                end else begin
                    // Owner's own request is ignored here so the other port gets a turn.
                    prio_next  = other;
                    beat_next  = '0;
                    state_next = req_v[other] ? (owner ? OWN0 : OWN1) : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            prio_reg  <= 1'b0;
            beat_reg  <= '0;
        end else begin
            state_reg <= state_next;
            prio_reg  <= prio_next;
            beat_reg  <= beat_next;
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MAXBEATS, default 8, maximum consecutive locked beats per grant (2..16).
REQ-002 Parameter: WIDTH, default 32, address/data width.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset; reset=0 forces reset state immediately, independent of clk.
REQ-005 req0, req1  input  1 each  access request from port 0 (CPU) and port 1 (loader/DMA).
REQ-006 we0, we1  input  1 each  write-enable qualifier of the request.
REQ-007 lock0, lock1  input  1 each  requester holds the grant for another beat after the current ack.
REQ-008 adr0, adr1, wd0, wd1  input  WIDTH each  request address and write data.
REQ-009 gnt0, gnt1  output  1 each  port owns the memory this cycle.
REQ-010 ack0, ack1  output  1 each  port's access completes this cycle.
REQ-011 rdata  output  WIDTH  read data, equal to mem_rd, valid when ackX=1 and weX=0.
REQ-012 mem_adr, mem_wd  output  WIDTH each  address and write data to the single-port memory.
REQ-013 mem_we  output  1  memory write enable; the write commits at the posedge ending the ack cycle.
REQ-014 mem_rd  input  WIDTH  combinational read data from memory.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, OWN0 and OWN1; gntX SHALL be 1 if and only if state=OWNX.
REQ-016 Registers: state, prio (1 bit, the port favoured on a tie), beat (counter of width ceil(log2(MAXBEATS))).
REQ-017 Outputs SHALL be combinational from the registers and inputs as follows.
- ackX = gntX & reqX.
- mem_we = ackX & weX.
- mem_adr/mem_wd = owner's adrX/wdX while gntX=1, else 0.
REQ-018 IDLE transitions:
- req0 & req1 -> OWN[prio].
- Only req0 -> OWN0; only req1 -> OWN1.
- Neither -> stay in IDLE.
- beat <= 0 on any grant.
REQ-019 Request-to-ack latency from IDLE SHALL be exactly 1 cycle: req seen at edge n, gnt/ack during cycle n+1.
REQ-020 From OWNX with ackX=1, lockX=1 and beat < MAXBEATS-1: stay in OWNX and increment beat, giving back-to-back beats at 1 per cycle.
REQ-021 From OWNX in every other case (release):
- prio <= other port Y.
- beat <= 0.
- Next state = OWNY if reqY=1, else IDLE.
- reqX in the releasing cycle SHALL NOT count as a new request.
REQ-022 A locked burst SHALL be force-released after MAXBEATS beats even with lockX=1; the other port then wins any tie.
REQ-023 In OWNX with reqX=0 (request retracted), there is no ack and no write, and the FSM releases per REQ-021.
REQ-024 Requesters SHALL hold reqX, weX, adrX and wdX stable until ackX; the arbiter is not required to tolerate changes before ack.
REQ-025 A port that releases and still requests SHALL get its next grant no earlier than 1 cycle after release (via IDLE or after the other port's turn), so no port starves while the other bursts.
REQ-026 No cycle SHALL have gnt0 & gnt1, or mem_we=1 while in IDLE.
REQ-027 Simultaneous reqY assertion and ownerX release SHALL hand over in 0 idle cycles (OWNX -> OWNY).

Reset
REQ-028 On reset=0:
- state=IDLE, prio=0, beat=0.
- gnt0=gnt1=ack0=ack1=mem_we=0 and mem_adr=mem_wd=0.
REQ-029 Reset asserted mid-burst SHALL abort the grant immediately; the in-flight write SHALL NOT commit unless the posedge precedes reset assertion.
REQ-030 After reset deasserts, the first arbitration occurs at the first posedge with reset=1.

Verification
REQ-031 Single read: req0=1, we0=0, adr0=0x10 in IDLE; memory holds 0xDEADBEEF at 0x10 -> next cycle gnt0=ack0=1, mem_adr=0x10, rdata=0xDEADBEEF, mem_we=0, then state=IDLE.
REQ-032 Tie and rotation: req0=req1=1 from reset (both writes) -> port 0 acked first, then port 1 acked the very next cycle, prio=0 after port 1 releases; mem_we pulses for exactly 2 cycles.
REQ-033 Locked burst cap: port 1 holds req1=lock1=1 with MAXBEATS=8 and req0=1 throughout -> ack1 for exactly 8 consecutive cycles, then gnt0=1 the following cycle.
REQ-034 Retract: req1 rises, then falls in the first OWN1 cycle -> ack1=0 and mem_we=0 that cycle, and the FSM returns to IDLE (or OWN0 if req0=1).
REQ-035 Async reset mid-burst: reset=0 asserted between edges during beat 3 of a port 0 write burst -> gnt0, ack0 and mem_we fall without a clock edge, and no further memory location changes.
REQ-036 Random stress: random req/we/lock on both ports for 10k cycles -> never gnt0 & gnt1, every held request acked within MAXBEATS+1 cycles, and memory contents match a reference model.
